// File: rtl/multicore_clocks_div_gen.sv
// multicore_clocks_div_gen
// N-channel clock-enable / divided-clock generator running on the PLL
// reference clock. Each channel has a runtime-programmable divide D and
// phase P. After any accepted reconfiguration, every channel is realigned
// in a single ALIGN cycle. The lock indication rises after a settling window.
//
// Optional feature: define MULTICORE_CLKGEN_GATE_EN to add a per-channel
// ch_gate input. The gate is sampled only at the period boundary, so gating
// never produces runt pulses and never disturbs the phase grid.

module multicore_clocks_div_gen #(
    parameter int  N_CH        = 2,
    parameter int  CNT_W       = 8,
    parameter int  LOCK_CYCLES = 16,
    parameter int  DEF_DIV     = 1,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LK_W        = $clog2(LOCK_CYCLES + 1)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
`ifdef MULTICORE_CLKGEN_GATE_EN
    input  logic [N_CH-1:0]   ch_gate,
`endif
    output logic              cfg_ready,
    output logic [N_CH-1:0]   clk_en,
    output logic [N_CH-1:0]   clk_out,
    output logic              locked
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIGN  = 2'd1,
        S_SETTLE = 2'd2,
        S_LOCKED = 2'd3
    } state_e;

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    // Control state
    state_e            state_q;
    logic [LK_W-1:0]   lock_cnt_q;
    logic              locked_q;
    logic              cfg_ready_q;

    // Per-channel configuration and counters
    logic [CNT_W-1:0]  div_q   [N_CH];
    logic [CNT_W-1:0]  div_d   [N_CH];
    logic [CNT_W-1:0]  phase_q [N_CH];
    logic [CNT_W-1:0]  phase_d [N_CH];
    logic [CNT_W-1:0]  cnt_q   [N_CH];
    logic [CNT_W-1:0]  cnt_d   [N_CH];
    logic [N_CH-1:0]   clk_out_q;
    logic [N_CH-1:0]   clk_out_d;
    logic [N_CH-1:0]   gate_q;
`ifdef MULTICORE_CLKGEN_GATE_EN
    logic [N_CH-1:0]   gate_d;
`endif

    // Write decode
    logic              wr_acc;
    logic              wr_hit;
    logic              run;
    logic [CNT_W-1:0]  wr_div;
    logic [CNT_W-1:0]  wr_phase;

    // Number of low cycles in one output period: ceil(d/2), overflow-free.
    function automatic logic [CNT_W-1:0] ceil_half(input logic [CNT_W-1:0] d);
        return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
    endfunction

    // A zero divide behaves as divide-by-one.
    function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // Phase cannot exceed one period minus one cycle.
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] d);
        return (p > d - CNT_W'(1)) ? (d - CNT_W'(1)) : p;
    endfunction

    assign run      = (state_q == S_SETTLE) || (state_q == S_LOCKED);
    assign wr_acc   = cfg_wr && cfg_ready_q;
    // Writes to a non-existent channel are swallowed without realignment.
    assign wr_hit   = wr_acc && ({1'b0, cfg_ch} < N_CH_L);
    assign wr_div   = sat_div(cfg_div);
    assign wr_phase = clamp_phase(cfg_phase, wr_div);

    // Control FSM: sequencing, lock counting and registered status outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_ALIGN;
                    cfg_ready_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
                S_ALIGN: begin
                    state_q     <= S_SETTLE;
                    lock_cnt_q  <= '0;
                    cfg_ready_q <= 1'b1;
                    locked_q    <= 1'b0;
                end
                S_SETTLE: begin
                    // A realigning write takes priority over lock expiry.
                    if (wr_hit) begin
                        state_q     <= S_ALIGN;
                        cfg_ready_q <= 1'b0;
                        locked_q    <= 1'b0;
                    end else if (lock_cnt_q == LK_W'(LOCK_CYCLES - 1)) begin
                        state_q    <= S_LOCKED;
                        lock_cnt_q <= lock_cnt_q + LK_W'(1);
                        locked_q   <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LK_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (wr_hit) begin
                        state_q     <= S_ALIGN;
                        cfg_ready_q <= 1'b0;
                        locked_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel next state: config update, counter align/run, clk_out level.
    always_comb begin
        clk_out_d = '0;
`ifdef MULTICORE_CLKGEN_GATE_EN
        gate_d = gate_q;
`endif
        for (int i = 0; i < N_CH; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            cnt_d[i]   = cnt_q[i];

            if (state_q == S_ALIGN) begin
                // Preload so that the first strobe lands P cycles after ALIGN.
                cnt_d[i] = div_q[i] - CNT_W'(1) - phase_q[i];
            end else if (run) begin
                if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                    cnt_d[i] = '0;
`ifdef MULTICORE_CLKGEN_GATE_EN
                    gate_d[i] = ch_gate[i];
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                clk_out_d[i] = gate_q[i] && (cnt_q[i] >= ceil_half(div_q[i]));
            end

            if (wr_hit && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = wr_div;
                phase_d[i] = wr_phase;
            end
        end
    end

    // Per-channel registers; programmed values are lost on reset.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= CNT_W'(DEF_DIV);
                phase_q[i] <= '0;
            end
            clk_out_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
            end
            clk_out_q <= clk_out_d;
        end
    end

`ifdef MULTICORE_CLKGEN_GATE_EN
    // Gate latched at each period boundary so whole periods are kept or dropped.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= '1;
        end else begin
            gate_q <= gate_d;
        end
    end
`else
    assign gate_q = '1;
`endif

    // Strobe decoded straight from the counters; suppressed outside run states.
    always_comb begin
        clk_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            clk_en[i] = run && gate_q[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
        end
    end

    assign clk_out   = clk_out_q;
    assign locked    = locked_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_multicore_clocks_div_gen.sv
// Directed bench for multicore_clocks_div_gen (N_CH=2, CNT_W=8,
// LOCK_CYCLES=16, DEF_DIV=1). Time t=0 is the first cycle after ALIGN.

module tb_multicore_clocks_div_gen;

    logic        refclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [0:0]  cfg_ch = '0;
    logic [7:0]  cfg_div = '0;
    logic [7:0]  cfg_phase = '0;
    logic        cfg_ready;
    logic [1:0]  clk_en;
    logic [1:0]  clk_out;
    logic        locked;
`ifdef MULTICORE_CLKGEN_GATE_EN
    logic [1:0]  ch_gate = 2'b11;
`endif

    int n_run  = 0;
    int n_fail = 0;

    multicore_clocks_div_gen #(
        .N_CH(2), .CNT_W(8), .LOCK_CYCLES(16), .DEF_DIV(1)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
`ifdef MULTICORE_CLKGEN_GATE_EN
        .ch_gate   (ch_gate),
`endif
        .cfg_ready (cfg_ready),
        .clk_en    (clk_en),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // One-cycle config write; returns sampled in the cycle after the accepting edge.
    task automatic do_write(input int ch, input int d, input int p);
        cfg_wr    = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_div   = 8'(d);
        cfg_phase = 8'(p);
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        rst_n = 1'b0;
        repeat (3) tick();
        n_run++;
        if ({cfg_ready, locked, clk_en, clk_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b lk=%b en=%b out=%b want all 0",
                     cfg_ready, locked, clk_en, clk_out);
        end
        rst_n = 1'b1;
        tick();  // IDLE -> ALIGN
        n_run++;
        if ({cfg_ready, clk_en, clk_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_align: got rdy=%b en=%b out=%b want 0/00/00",
                     cfg_ready, clk_en, clk_out);
        end
        for (int n = 1; n <= 17; n++) begin
            tick();
            exp_v = {(n >= 17) ? 1'b1 : 1'b0, 1'b1, 2'b11};
            n_run++;
            if ({locked, cfg_ready, clk_en} !== exp_v || clk_out !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_settle n=%0d: got lk/rdy/en=%b out=%b want %b out=00",
                         n, {locked, cfg_ready, clk_en}, clk_out, exp_v);
            end
        end
    endtask

    task automatic test_phase_offset();
        logic [15:0] p_en0, p_en1, p_out0, p_out1;
        p_en0  = 16'h0111;
        p_en1  = 16'h0444;
        p_out0 = 16'h0332;
        p_out1 = 16'h0CCC;
        do_write(0, 4, 0);
        n_run++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_realign: got lk=%b rdy=%b want 0 0", locked, cfg_ready);
        end
        tick();
        do_write(1, 4, 2);
        tick();
        for (int t = 0; t < 12; t++) begin
            n_run++;
            if (clk_en !== {p_en1[t], p_en0[t]} || clk_out !== {p_out1[t], p_out0[t]}) begin
                n_fail++;
                $display("FAIL phase_offset t=%0d: got en=%b out=%b want en=%b out=%b",
                         t, clk_en, clk_out, {p_en1[t], p_en0[t]}, {p_out1[t], p_out0[t]});
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        logic [15:0] p_en0, p_out0;
        p_en0  = 16'h4210;
        p_out0 = 16'hC630;
        do_write(0, 5, 9);
        tick();
        do_write(1, 0, 3);
        tick();
        for (int t = 0; t < 16; t++) begin
            n_run++;
            if (clk_en !== {1'b1, p_en0[t]} || clk_out !== {1'b0, p_out0[t]}) begin
                n_fail++;
                $display("FAIL clamp t=%0d: got en=%b out=%b want en=%b out=%b",
                         t, clk_en, clk_out, {1'b1, p_en0[t]}, {1'b0, p_out0[t]});
            end
            tick();
        end
    endtask

    task automatic test_locked_drop();
        // 17 cycles after the last ALIGN: lock must be up.
        n_run++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_after_clamp: got %b want 1", locked);
        end
        do_write(0, 4, 0);
        n_run++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_drop: got lk=%b rdy=%b want 0 0", locked, cfg_ready);
        end
        repeat (16) tick();
        n_run++;
        if (locked !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_expiry: got lk=%b rdy=%b want 0 1", locked, cfg_ready);
        end
        do_write(0, 4, 0);
        n_run++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_on_expiry: got lk=%b rdy=%b want 0 0", locked, cfg_ready);
        end
        tick();
        n_run++;
        if (locked !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_back: got lk=%b rdy=%b want 0 1", locked, cfg_ready);
        end
    endtask

    task automatic test_reset_mid();
        tick();  // t=1: ch0 D=4 high, ch1 D=1 strobing
        n_run++;
        if (clk_out !== 2'b01 || clk_en !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_precond: got en=%b out=%b want en=10 out=01", clk_en, clk_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({cfg_ready, locked, clk_en, clk_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got rdy=%b lk=%b en=%b out=%b want all 0",
                     cfg_ready, locked, clk_en, clk_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int t = 0; t < 6; t++) begin
            n_run++;
            if (clk_en !== 2'b11 || clk_out !== 2'b00 || cfg_ready !== 1'b1 || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL def_div_restored t=%0d: got en=%b out=%b rdy=%b lk=%b want 11 00 1 0",
                         t, clk_en, clk_out, cfg_ready, locked);
            end
            tick();
        end
    endtask

`ifdef MULTICORE_CLKGEN_GATE_EN
    task automatic test_gate();
        logic [31:0] p_en1, p_out1;
        p_en1  = 32'h0001_0011;
        p_out1 = 32'h0003_0032;
        do_write(1, 4, 0);
        tick();
        for (int t = 0; t < 18; t++) begin
            n_run++;
            if (clk_en[1] !== p_en1[t] || clk_out[1] !== p_out1[t]) begin
                n_fail++;
                $display("FAIL gate t=%0d: got en1=%b out1=%b want en1=%b out1=%b",
                         t, clk_en[1], clk_out[1], p_en1[t], p_out1[t]);
            end
            if (t == 1) ch_gate = 2'b01;
            if (t == 9) ch_gate = 2'b11;
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_phase_offset();
        test_clamp();
        test_locked_drop();
        test_reset_mid();
`ifdef MULTICORE_CLKGEN_GATE_EN
        test_gate();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
